// File: rtl/ghadi_display_scan_if.sv
// Bus between the clock core and the display scanner: BCD time digits and alarm in, panel drive out.
// Combinational wiring only, so no latency.
// No backpressure: the display samples the digit levels whenever it needs them.
interface ghadi_display_scan_if;
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [3:0] M_in1;
    logic [3:0] M_in0;
    logic [3:0] S_in1;
    logic [3:0] S_in0;
    logic       Alarm;
    logic [6:0] seg;
    logic [5:0] an;
    logic       dp;
    logic       frame_done;

    modport master (
        output H_in1, H_in0, M_in1, M_in0, S_in1, S_in0, Alarm,
        input  seg, an, dp, frame_done
    );

    modport slave (
        input  H_in1, H_in0, M_in1, M_in0, S_in1, S_in0, Alarm,
        output seg, an, dp, frame_done
    );
endinterface

// File: rtl/ghadi_display_scan.sv
// Six-digit multiplexed common-anode seven-segment scanner with a per-frame snapshot, blank slots and alarm blink.
// Segment, anode and decimal-point drive is registered, one cycle behind the scan counters.
// No backpressure: digits are level inputs and are captured only at frame boundaries.
module ghadi_display_scan #(
    parameter int SCAN_DIV     = 4096,
    parameter int BLINK_FRAMES = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    ghadi_display_scan_if.slave  bus
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);
    localparam logic [6:0]    SEG_BLANK = 7'h7F;
    localparam logic [5:0]    AN_OFF    = 6'h3F;

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic          primed;
    logic [1:0]    snap_h1;
    logic [3:0]    snap_h0;
    logic [3:0]    snap_m1;
    logic [3:0]    snap_m0;
    logic [3:0]    snap_s1;
    logic [3:0]    snap_s0;
    logic          snap_alarm;
    logic [BW-1:0] blink_cnt;
    logic          phase;

    logic [6:0]    seg_q;
    logic [5:0]    an_q;
    logic          dp_q;
    logic          frame_done_q;

    logic          tick;
    logic          wrap;
    logic          load;
    logic [3:0]    digit;
    logic [6:0]    seg_nxt;
    logic [5:0]    an_nxt;
    logic          dp_nxt;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    always_comb begin
        tick = (cnt == CNT_MAX);
        wrap = tick && (idx == 3'd5);
        // The first cycle out of reset loads too, so frame 0 never shows the cleared snapshot.
        load = wrap || !primed;
    end

    always_comb begin
        digit = 4'd0;
        case (idx)
            3'd0:    digit = snap_s0;
            3'd1:    digit = snap_s1;
            3'd2:    digit = snap_m0;
            3'd3:    digit = snap_m1;
            3'd4:    digit = snap_h0;
            3'd5:    digit = {2'b00, snap_h1};
            default: digit = 4'd0;
        endcase
    end

    always_comb begin
        seg_nxt = SEG_BLANK;
        an_nxt  = AN_OFF;
        dp_nxt  = 1'b1;
        // cnt==0 is the anti-ghosting slot: all anodes off while the segment lines settle.
        if ((cnt != '0) && phase) begin
            an_nxt = ~(6'd1 << idx);
            if ((idx == 3'd5) && (snap_h1 == 2'd0)) begin
                seg_nxt = SEG_BLANK;
            end else begin
                seg_nxt = decode(digit);
                dp_nxt  = !((idx == 3'd2) || (idx == 3'd4));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            idx          <= 3'd0;
            primed       <= 1'b0;
            snap_h1      <= 2'd0;
            snap_h0      <= 4'd0;
            snap_m1      <= 4'd0;
            snap_m0      <= 4'd0;
            snap_s1      <= 4'd0;
            snap_s0      <= 4'd0;
            snap_alarm   <= 1'b0;
            blink_cnt    <= '0;
            phase        <= 1'b1;
            seg_q        <= SEG_BLANK;
            an_q         <= AN_OFF;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            cnt          <= tick ? '0 : cnt + CW'(1);
            primed       <= 1'b1;
            frame_done_q <= wrap;
            seg_q        <= seg_nxt;
            an_q         <= an_nxt;
            dp_q         <= dp_nxt;

            if (tick) begin
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end

            if (load) begin
                snap_h1    <= bus.H_in1;
                snap_h0    <= bus.H_in0;
                snap_m1    <= bus.M_in1;
                snap_m0    <= bus.M_in0;
                snap_s1    <= bus.S_in1;
                snap_s0    <= bus.S_in0;
                snap_alarm <= bus.Alarm;
            end

            // Blink state follows the alarm of the frame currently on screen, not the live input.
            if (!snap_alarm) begin
                phase     <= 1'b1;
                blink_cnt <= '0;
            end else if (wrap) begin
                if (blink_cnt == BLINK_MAX) begin
                    phase     <= !phase;
                    blink_cnt <= '0;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_ghadi_display_scan.sv
// Randomized bench for the display scanner, checked every cycle against a frame-level reference model.
module tb_ghadi_display_scan;

    localparam int SD = 4;
    localparam int BF = 2;
    localparam int FL = 6 * SD;

    typedef struct packed {
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
        logic       al;
    } in_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ghadi_display_scan_if bus ();

    ghadi_display_scan #(.SCAN_DIV(SD), .BLINK_FRAMES(BF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [6:0] seg_tab [16];
    initial begin
        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp, input int edge_no);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (edge %0d after reset)", tag, got, exp, edge_no);
    endtask

    // Model: inputs seen at every non-reset edge k are logged in hist[k]; outputs after
    // edge k are derived from the scan position q=k-1 and the frame's captured inputs.
    in_t  hist [$];
    int   k        = 0;
    bit   model_ok = 1'b0;
    bit   done     = 1'b0;
    logic [6:0] e_seg;
    logic [5:0] e_an;
    logic       e_dp;
    logic       e_fd;

    function automatic int snap_at(int f);
        return (f == 0) ? 1 : f * FL;
    endfunction

    function automatic bit visible(int f);
        int r = 0;
        int j = f - 1;
        if (!hist[snap_at(f)].al) return 1'b1;
        while (j >= 0 && hist[snap_at(j)].al) begin
            r++;
            j--;
        end
        return ((r / BF) % 2) == 0;
    endfunction

    function automatic logic [3:0] digit_of(in_t s, int i);
        case (i)
            0: return s.s0;
            1: return s.s1;
            2: return s.m0;
            3: return s.m1;
            4: return s.h0;
            default: return {2'b00, s.h1};
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            hist.delete();
            hist.push_back('0);
            k = 0;
            model_ok = 1'b1;
            e_seg = 7'h7F; e_an = 6'h3F; e_dp = 1'b1; e_fd = 1'b0;
        end else if (model_ok) begin
            int q, pos, id, f;
            in_t s;
            hist.push_back('{bus.H_in1, bus.H_in0, bus.M_in1, bus.M_in0, bus.S_in1, bus.S_in0, bus.Alarm});
            k++;
            q   = k - 1;
            pos = q % SD;
            id  = (q / SD) % 6;
            f   = q / FL;
            e_fd  = (q % FL) == (FL - 1);
            e_seg = 7'h7F; e_an = 6'h3F; e_dp = 1'b1;
            if (pos != 0 && visible(f)) begin
                s = hist[snap_at(f)];
                e_an = ~(6'd1 << id);
                if (!(id == 5 && s.h1 == 2'd0)) begin
                    e_seg = seg_tab[digit_of(s, id)];
                    e_dp  = !(id == 2 || id == 4);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok && !done) begin
            chk("seg", 32'(bus.seg), 32'(e_seg), k);
            chk("an", 32'(bus.an), 32'(e_an), k);
            chk("dp", 32'(bus.dp), 32'(e_dp), k);
            chk("frame_done", 32'(bus.frame_done), 32'(e_fd), k);
        end
    end

    task automatic set_time(input logic [1:0] h1, input logic [3:0] h0, input logic [3:0] m1,
                            input logic [3:0] m0, input logic [3:0] s1, input logic [3:0] s0);
        bus.H_in1 = h1; bus.H_in0 = h0; bus.M_in1 = m1;
        bus.M_in0 = m0; bus.S_in1 = s1; bus.S_in0 = s0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset = 1'b1;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        set_time(2'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
        bus.Alarm = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3 * FL) @(negedge clk);

        // Reset held mid-scan, then a frame with a leading hour zero.
        repeat (7) @(negedge clk);
        do_reset(3);
        set_time(2'd0, 4'd9, 4'd5, 4'd9, 4'd5, 4'd9);
        repeat (2 * FL) @(negedge clk);

        // Minute change mid-frame, then an invalid BCD minute digit.
        repeat (SD + 2) @(negedge clk);
        bus.M_in0 = 4'd7;
        repeat (FL) @(negedge clk);
        bus.M_in0 = 4'hC;
        repeat (2 * FL) @(negedge clk);

        // Alarm blinking, dropped part-way through a dark frame.
        bus.Alarm = 1'b1;
        repeat (11 * FL + 5) @(negedge clk);
        bus.Alarm = 1'b0;
        repeat (3 * FL) @(negedge clk);

        // Reset sampled on the very edge that would wrap the frame.
        for (int t = 0; t < 3 * FL; t++) begin
            if (k % FL == FL - 1) break;
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (2 * FL) @(negedge clk);

        for (int it = 0; it < 300; it++) begin
            repeat ($urandom_range(1, 30)) @(negedge clk);
            case ($urandom_range(0, 6))
                0: bus.H_in1 = 2'($urandom_range(0, 3));
                1: bus.H_in0 = 4'($urandom);
                2: bus.M_in1 = 4'($urandom);
                3: bus.M_in0 = 4'($urandom);
                4: bus.S_in1 = 4'($urandom);
                5: bus.S_in0 = 4'($urandom);
                default: set_time(2'($urandom_range(0, 3)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)),
                                  4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9)));
            endcase
            if ($urandom_range(0, 11) == 0) bus.Alarm = ~bus.Alarm;
            if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 4));
        end

        repeat (FL) @(negedge clk);
        done = 1'b1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
